// File: rtl/rbr_pkg.sv
// rtl/rbr_pkg.sv - redundant binary representation types shared by the root datapath
package rbr_pkg;

    // Digit value is plus - minus; {0,0} and {1,1} both encode zero.
    typedef struct packed {
        logic plus;
        logic minus;
    } signed_digit;

endpackage

// File: rtl/so3s_otfc_seq.sv
// rtl/so3s_otfc_seq.sv - sequential on-the-fly converter for the SO3S online square root
// Keeps Q and QM = Q - ulp(j) live; every update is a single-bit OR or a register copy.
module so3s_otfc_seq #(
    parameter int N_DIGITS = 8,
    parameter int WIDTH    = N_DIGITS + 1,
    parameter int J_W      = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                digit_valid,
    input  rbr_pkg::signed_digit digit,
    output logic                digit_ready,
    output logic [WIDTH-1:0]    q,
    output logic [WIDTH-1:0]    qm,
    output logic [J_W-1:0]      j,
    output logic                busy,
    output logic [WIDTH-1:0]    result,
    output logic                result_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MINUS_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [J_W-1:0]   J_LAST    = J_W'(N_DIGITS - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_nx, qm_nx, result_nx;
    logic [WIDTH-1:0] q_acc, qm_acc, pos_bit;
    logic [J_W-1:0]   j_nx;
    logic             d_pos, d_neg;

    assign d_pos   = digit.plus & ~digit.minus;
    assign d_neg   = digit.minus & ~digit.plus;
    // Weight of the digit being accepted: 2^-(j+1) in the fixed-point frame.
    assign pos_bit = WIDTH'(1) << (J_LAST - j);

    assign digit_ready  = (state == RUN);
    assign busy         = (state == RUN);
    assign result_valid = (state == DONE);

    always_comb begin
        q_acc  = q;
        qm_acc = qm;
        if (d_pos) begin
            q_acc  = q | pos_bit;
            qm_acc = q;
        end else if (d_neg) begin
            q_acc  = qm | pos_bit;
        end else begin
            qm_acc = qm | pos_bit;
        end
    end

    always_comb begin
        state_nx  = state;
        q_nx      = q;
        qm_nx     = qm;
        j_nx      = j;
        result_nx = result;
        case (state)
            IDLE: begin
                if (start) begin
                    q_nx     = '0;
                    qm_nx    = MINUS_ONE;
                    j_nx     = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // An abort wins over a digit presented in the same cycle.
                if (start) begin
                    q_nx  = '0;
                    qm_nx = MINUS_ONE;
                    j_nx  = '0;
                end else if (digit_valid) begin
                    q_nx  = q_acc;
                    qm_nx = qm_acc;
                    if (j == J_LAST) begin
                        result_nx = q_acc;
                        state_nx  = DONE;
                    end else begin
                        j_nx = j + J_W'(1);
                    end
                end
            end
            DONE: begin
                if (start) begin
                    q_nx     = '0;
                    qm_nx    = MINUS_ONE;
                    j_nx     = '0;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            qm     <= '0;
            j      <= '0;
            result <= '0;
        end else begin
            state  <= state_nx;
            q      <= q_nx;
            qm     <= qm_nx;
            j      <= j_nx;
            result <= result_nx;
        end
    end

endmodule

// File: tb/tb_so3s_otfc_seq.sv
// tb/tb_so3s_otfc_seq.sv - self-checking bench for so3s_otfc_seq (N_DIGITS=4)
module tb_so3s_otfc_seq;

    localparam int N = 4;
    localparam int W = N + 1;

    logic                 clk = 1'b0;
    logic                 rst, start, digit_valid;
    rbr_pkg::signed_digit digit;
    logic                 digit_ready, busy, result_valid;
    logic [W-1:0]         q, qm, result;
    logic [1:0]           j;

    so3s_otfc_seq #(.N_DIGITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid), .digit(digit),
        .digit_ready(digit_ready), .q(q), .qm(qm), .j(j), .busy(busy),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           d[4];
        int           max_gap;
        int           enc11_idx;
        logic [W-1:0] exp_result;
        logic [W-1:0] exp_qm;
    } vec_t;

    vec_t         vecs[4];
    logic [W-1:0] sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           rv_pulses = 0;
    int           m_q = 0;
    int           m_k = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (result_valid) rv_pulses <= rv_pulses + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [W-1:0] eq, eqm;
        eq  = W'(m_q);
        eqm = W'(m_q - (1 << (N - m_k)));
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_qm"}, 32'(qm), 32'(eqm));
        chk({tag, "_j"}, 32'(j), (m_k < N) ? 32'(m_k) : 32'(N - 1));
    endtask

    task automatic start_op();
        digit_valid = 1'b0;
        start       = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start = 1'b0;
        m_q = 0;
        m_k = 0;
        chk("init_q", 32'(q), 32'(0));
        chk("init_qm", 32'(qm), 32'(5'b10000));
        chk("init_j", 32'(j), 32'(0));
        chk("init_ready", 32'(digit_ready), 32'(1));
    endtask

    task automatic send_digit(input int d, input int gap, input bit enc11);
        logic [W-1:0] q0, qm0;
        logic [1:0]   j0;
        for (int g = 0; g < gap; g++) begin
            q0 = q; qm0 = qm; j0 = j;
            digit_valid = 1'b0;
            digit       = rbr_pkg::signed_digit'(2'($urandom));
            @(negedge clk);
            chk("gap_hold", 32'({q, qm, j}), 32'({q0, qm0, j0}));
        end
        if (d > 0)      digit = '{plus: 1'b1, minus: 1'b0};
        else if (d < 0) digit = '{plus: 1'b0, minus: 1'b1};
        else            digit = enc11 ? '{plus: 1'b1, minus: 1'b1} : '{plus: 1'b0, minus: 1'b0};
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        m_k++;
        m_q += d * (1 << (N - m_k));
        chk_model("accept");
    endtask

    task automatic finish_op(input bit chk_lat);
        logic [W-1:0] exp;
        logic [W-1:0] held;
        int w = 0;
        while (!result_valid && w < 8) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!result_valid) begin
            errors++;
            $display("FAIL result_valid_timeout actual=0 expected=1");
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=result_valid expected=no_output");
        end else begin
            exp = sb.pop_front();
            chk("result", 32'(result), 32'(exp));
            if (chk_lat) chk("latency", 32'(cyc - start_cyc), 32'(N + 1));
        end
        held = result;
        @(negedge clk);
        chk("rv_cleared", 32'(result_valid), 32'(0));
        chk("result_hold", 32'(result), 32'(held));
        chk("idle_ready", 32'({busy, digit_ready}), 32'(0));
    endtask

    task automatic run_vec(input int i);
        start_op();
        sb.push_back(vecs[i].exp_result);
        for (int k = 0; k < N; k++)
            send_digit(vecs[i].d[k],
                       (vecs[i].max_gap > 0) ? int'($urandom_range(vecs[i].max_gap, 0)) : 0,
                       vecs[i].enc11_idx == k);
        finish_op(vecs[i].max_gap == 0);
        chk("final_qm", 32'(qm), 32'(vecs[i].exp_qm));
    endtask

    initial begin
        int rv0;
        vecs[0] = '{d: '{ 1,  0,  0,  0}, max_gap: 0, enc11_idx: -1, exp_result: 5'b01000, exp_qm: 5'b00111};
        vecs[1] = '{d: '{ 1, -1,  1, -1}, max_gap: 0, enc11_idx: -1, exp_result: 5'b00101, exp_qm: 5'b00100};
        vecs[2] = '{d: '{-1, -1, -1, -1}, max_gap: 0, enc11_idx: -1, exp_result: 5'b10001, exp_qm: 5'b10000};
        vecs[3] = '{d: '{ 0,  0,  0,  0}, max_gap: 3, enc11_idx:  2, exp_result: 5'b00000, exp_qm: 5'b11111};

        rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outs", 32'({q, qm, j, result}), 32'(0));
        chk("reset_flags", 32'({busy, digit_ready, result_valid}), 32'(0));

        for (int i = 0; i < 4; i++) run_vec(i);

        // Abort after two digits with a digit offered alongside the start.
        start_op();
        send_digit(1, 0, 1'b0);
        send_digit(1, 0, 1'b0);
        rv0 = rv_pulses;
        digit = '{plus: 1'b1, minus: 1'b0};
        digit_valid = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        digit_valid = 1'b0;
        m_q = 0;
        m_k = 0;
        chk("abort_q", 32'(q), 32'(0));
        chk("abort_qm", 32'(qm), 32'(5'b10000));
        chk("abort_j", 32'(j), 32'(0));
        chk("abort_busy", 32'(busy), 32'(1));
        chk("abort_result", 32'(result), 32'(5'b00000));
        sb.push_back(5'b00100);
        send_digit(0, 0, 1'b0);
        send_digit(1, 0, 1'b0);
        send_digit(0, 0, 1'b0);
        send_digit(0, 0, 1'b0);
        finish_op(1'b1);
        repeat (2) @(negedge clk);
        chk("abort_pulses", 32'(rv_pulses - rv0), 32'(1));

        // Start pulsed in DONE: back-to-back operation.
        start_op();
        sb.push_back(5'b01110);
        for (int k = 0; k < N; k++) send_digit((k == 3) ? 0 : 1, 0, 1'b0);
        chk("done_rv", 32'(result_valid), 32'(1));
        chk("done_result", 32'(result), 32'(sb.pop_front()));
        start_op();
        sb.push_back(5'b11011);
        send_digit(-1, 0, 1'b0);
        send_digit(0, 0, 1'b0);
        send_digit(1, 0, 1'b0);
        send_digit(1, 0, 1'b0);
        finish_op(1'b1);

        // Reset in RUN overrides start and digit.
        start_op();
        send_digit(1, 0, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        digit_valid = 1'b1;
        digit = '{plus: 1'b1, minus: 1'b0};
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        digit_valid = 1'b0;
        chk("rst_outs", 32'({q, qm, j, result}), 32'(0));
        chk("rst_flags", 32'({busy, digit_ready, result_valid}), 32'(0));
        run_vec(0);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
